// File: rtl/spi_wb_bridge_if.sv
// Wishbone B3 master-side bundle for the SPI-to-Wishbone bridge.
`timescale 1ns/1ps
interface spi_wb_bridge_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 target bridging host commands to single 32-bit Wishbone cycles.
// Optional bus watchdog enabled by defining SPI_WB_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_wb_bridge #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_wb_bridge_if.master wb
);
  // state   | meaning
  // IDLE    | deselected, waiting for cs_n fall
  // CMD     | shifting in command byte
  // ADDR    | shifting in 32-bit address
  // WDATA   | shifting in write words
  // RDUMMY  | dummy byte hiding first read latency
  // RDATA   | shifting out read words
  // STAT    | shifting out status byte
  // IGNORE  | unknown command or finished status, miso held 0
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] WDATA  = 3'd3;
  localparam logic [2:0] RDUMMY = 3'd4;
  localparam logic [2:0] RDATA  = 3'd5;
  localparam logic [2:0] STAT   = 3'd6;
  localparam logic [2:0] IGNORE = 3'd7;

  localparam logic BUS_IDLE = 1'b0;
  localparam logic BUS_WAIT = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic rise, fall, cs_fall;

  logic [2:0]  state;
  logic [4:0]  bit_cnt;
  logic [30:0] rx_sh, tx_sh;
  logic [31:0] rx_next, load_word;
  logic        is_read, ld_pend, miso_r;

  logic        bus_state, cyc, we, req_pend, pend_we, cur_drop, hold_v;
  logic [31:0] adr, dat, pend_dat, hold;
  logic        err_f, ovr_f, tmo;

  logic addr_done, word_done, copy, stat_done;
  logic bus_wait, bus_end, bus_fail, rd_live, hold_ok, can_take;
  logic wr_acc, wr_ovr, rd_req, req, copy_ovr;
  logic [31:0] rd_word, tx_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rise    = ~cs_s & sclk_s & ~sclk_d;
  assign fall    = ~cs_s & ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;

  assign rx_next   = {rx_sh, mosi_s};
  assign addr_done = rise && state == ADDR  && bit_cnt == 5'd31;
  assign word_done = rise && state == WDATA && bit_cnt == 5'd31;
  assign stat_done = rise && state == STAT  && bit_cnt == 5'd7;
  assign copy      = fall && state == RDATA && ld_pend;

  // A completing ack is visible to word/copy logic in the same clk, so it never counts as overrun.
  assign bus_wait = bus_state == BUS_WAIT;
  assign bus_end  = bus_wait & (wb.wb_ack_i | wb.wb_err_i | tmo);
  assign bus_fail = bus_wait & (wb.wb_err_i | tmo);
  assign rd_live  = bus_end & ~we & ~cur_drop;
  assign rd_word  = bus_fail ? 32'hDEADBEEF : wb.wb_dat_i;
  assign hold_ok  = rd_live | hold_v;
  assign tx_word  = rd_live ? rd_word : hold;
  assign can_take = ~req_pend & (~bus_wait | bus_end);
  assign wr_acc   = word_done & can_take;
  assign wr_ovr   = word_done & ~can_take;
  assign rd_req   = (addr_done & is_read) | (copy & (~bus_wait | bus_end));
  assign req      = wr_acc | rd_req;
  assign copy_ovr = copy & ~hold_ok;

  assign load_word = (state == STAT) ? {6'b0, err_f, ovr_f, 24'h0}
                                     : (hold_ok ? tx_word : 32'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      is_read <= 1'b0;
      ld_pend <= 1'b0;
      miso_r  <= 1'b0;
    end else if (cs_s) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      ld_pend <= 1'b0;
      miso_r  <= 1'b0;
    end else begin
      if (rise) begin
        rx_sh   <= rx_next[30:0];
        bit_cnt <= bit_cnt + 5'd1;
      end
      case (state)
        IDLE: if (cs_fall) begin
          state   <= CMD;
          bit_cnt <= '0;
        end
        CMD: if (rise && bit_cnt == 5'd7) begin
          bit_cnt <= '0;
          case (rx_next[7:0])
            8'h02: begin state <= ADDR; is_read <= 1'b0; end
            8'h03: begin state <= ADDR; is_read <= 1'b1; end
            8'h05: begin state <= STAT; ld_pend <= 1'b1; end
            default: state <= IGNORE;
          endcase
        end
        ADDR:   if (addr_done) state <= is_read ? RDUMMY : WDATA;
        RDUMMY: if (rise && bit_cnt == 5'd7) begin
          state   <= RDATA;
          bit_cnt <= '0;
          ld_pend <= 1'b1;
        end
        RDATA:  if (rise && bit_cnt == 5'd31) ld_pend <= 1'b1;
        STAT:   if (stat_done) state <= IGNORE;
        IGNORE: miso_r <= 1'b0;
        default: ;
      endcase
      if (fall && (state == RDATA || state == STAT)) begin
        if (ld_pend) begin
          ld_pend <= 1'b0;
          miso_r  <= load_word[31];
          tx_sh   <= load_word[30:0];
        end else begin
          miso_r  <= tx_sh[30];
          tx_sh   <= {tx_sh[29:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_state <= BUS_IDLE;
      cyc       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      dat       <= '0;
      req_pend  <= 1'b0;
      pend_we   <= 1'b0;
      pend_dat  <= '0;
      cur_drop  <= 1'b0;
      hold      <= '0;
      hold_v    <= 1'b0;
    end else begin
      if (addr_done)    adr <= {rx_next[31:2], 2'b00};
      else if (bus_end) adr <= adr + 32'd4;

      case (bus_state)
        BUS_IDLE: begin
          if (req_pend && !(cs_s && !pend_we)) begin
            bus_state <= BUS_WAIT;
            cyc       <= 1'b1;
            we        <= pend_we;
            if (pend_we) dat <= pend_dat;
            req_pend  <= 1'b0;
            cur_drop  <= 1'b0;
          end else if (req) begin
            bus_state <= BUS_WAIT;
            cyc       <= 1'b1;
            we        <= wr_acc;
            if (wr_acc) dat <= rx_next;
            cur_drop  <= 1'b0;
          end
        end
        default: begin
          if (bus_end) begin
            bus_state <= BUS_IDLE;
            cyc       <= 1'b0;
            we        <= 1'b0;
            if (req) begin
              req_pend <= 1'b1;
              pend_we  <= wr_acc;
              pend_dat <= rx_next;
            end
          end else if (cs_s) begin
            cur_drop <= 1'b1;
          end
        end
      endcase
      // Reads queued for a frame that has since been deselected are abandoned.
      if (cs_s && !pend_we) req_pend <= 1'b0;

      if (cs_s)         hold_v <= 1'b0;
      else if (copy)    hold_v <= 1'b0;
      else if (rd_live) begin
        hold   <= rd_word;
        hold_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_f <= 1'b0;
      ovr_f <= 1'b0;
    end else begin
      if (stat_done) begin
        err_f <= 1'b0;
        ovr_f <= 1'b0;
      end
      if (bus_fail)          err_f <= 1'b1;
      if (wr_ovr | copy_ovr) ovr_f <= 1'b1;
    end
  end

`ifdef SPI_WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tmo_cnt <= '0;
    else if (!bus_wait)      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    else if (tmo_cnt != '0)  tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign tmo = bus_wait & (tmo_cnt == '0);
`else
  // No watchdog in this build; the parameter is kept so both builds share one interface.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  assign wb.wb_adr_o = adr;
  assign wb.wb_dat_o = dat;
  assign wb.wb_we_o  = we;
  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = cyc;
  assign wb.wb_sel_o = {4{cyc}};
  assign spi_miso    = miso_r;
endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge: SPI host tasks plus a logging Wishbone slave.
`timescale 1ns/1ps
module tb_spi_wb_bridge;
  localparam int HP = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  spi_wb_bridge_if bus();

  spi_wb_bridge #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (sclk),
    .spi_cs_n (cs_n),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .wb       (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int ack_delay = 2;
  bit never_ack = 1'b0;
  int wait_cnt;
  int n_log = 0;
  logic [31:0] log_adr [64];
  logic [31:0] log_dat [64];
  logic        log_we  [64];
  logic [3:0]  log_sel [64];
  logic        log_stb [64];

  assign bus.wb_err_i = 1'b0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h02000000: return 32'hA5A5A5A5;
      32'h02000004: return 32'h0F0F0F0F;
      default:      return 32'h12345678;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_ack_i <= 1'b0;
      bus.wb_dat_i <= 32'h0;
      wait_cnt     <= 0;
    end else begin
      bus.wb_ack_i <= 1'b0;
      if (bus.wb_cyc_o && !bus.wb_ack_i && !never_ack) begin
        if (wait_cnt >= ack_delay) begin
          bus.wb_ack_i <= 1'b1;
          bus.wb_dat_i <= bus.wb_we_o ? 32'h0 : rd_model(bus.wb_adr_o);
          wait_cnt     <= 0;
          if (n_log < 64) begin
            log_adr[n_log] <= bus.wb_adr_o;
            log_dat[n_log] <= bus.wb_dat_o;
            log_we[n_log]  <= bus.wb_we_o;
            log_sel[n_log] <= bus.wb_sel_o;
            log_stb[n_log] <= bus.wb_stb_o;
          end
          n_log <= n_log + 1;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else if (!bus.wb_cyc_o) begin
        wait_cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [31:0] data, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = data[i];
      #HP;
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      #HP;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_on();
    cs_n = 1'b0;
    #HP;
  endtask

  task automatic cs_off();
    #HP;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(4 * HP);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.wb_cyc_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'b0, bus.wb_cyc_o}, 32'h0);
  endtask

  task automatic do_status(output logic [7:0] s);
    logic [31:0] r;
    cs_on();
    spi_bits(32'h05, 8, r);
    spi_bits(32'h00, 8, r);
    cs_off();
    s = r[7:0];
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] r;
    cs_on();
    spi_bits(32'h02, 8, r);
    spi_bits(a, 32, r);
    spi_bits(d0, 32, r);
    spi_bits(d1, 32, r);
    cs_off();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r1, r2;
    logic [7:0]  s;
    int base, n;

    repeat (4) @(negedge clk);
    chk("rst cyc",  {31'b0, bus.wb_cyc_o}, 32'h0);
    chk("rst stb",  {31'b0, bus.wb_stb_o}, 32'h0);
    chk("rst we",   {31'b0, bus.wb_we_o},  32'h0);
    chk("rst sel",  {28'b0, bus.wb_sel_o}, 32'h0);
    chk("rst adr",  bus.wb_adr_o, 32'h0);
    chk("rst dat",  bus.wb_dat_o, 32'h0);
    chk("rst miso", {31'b0, miso}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: two-word write
    base = n_log;
    do_write(32'h10004000, 32'h11223344, 32'h55667788);
    wait_idle("t1 idle");
    chk("t1 count", 32'(n_log - base), 32'd2);
    chk("t1 adr0", log_adr[base], 32'h10004000);
    chk("t1 dat0", log_dat[base], 32'h11223344);
    chk("t1 we0",  {31'b0, log_we[base]}, 32'h1);
    chk("t1 sel0", {28'b0, log_sel[base]}, 32'hF);
    chk("t1 stb0", {31'b0, log_stb[base]}, 32'h1);
    chk("t1 adr1", log_adr[base+1], 32'h10004004);
    chk("t1 dat1", log_dat[base+1], 32'h55667788);

    // 2: two-word read with 3-cycle ack
    base = n_log;
    cs_on();
    spi_bits(32'h03, 8, r);
    spi_bits(32'h02000000, 32, r);
    spi_bits(32'h00, 8, r);
    spi_bits(32'h0, 32, r1);
    spi_bits(32'h0, 32, r2);
    cs_off();
    wait_idle("t2 idle");
    chk("t2 word0", r1, 32'hA5A5A5A5);
    chk("t2 word1", r2, 32'h0F0F0F0F);
    chk("t2 adr0", log_adr[base], 32'h02000000);
    chk("t2 we0",  {31'b0, log_we[base]}, 32'h0);
    chk("t2 adr1", log_adr[base+1], 32'h02000004);

    // 3: address wrap
    base = n_log;
    do_write(32'hFFFFFFFC, 32'hCAFEF00D, 32'h0BADC0DE);
    wait_idle("t3 idle");
    chk("t3 adr0", log_adr[base], 32'hFFFFFFFC);
    chk("t3 adr1", log_adr[base+1], 32'h00000000);
    chk("t3 dat1", log_dat[base+1], 32'h0BADC0DE);
    do_status(s);
    chk("t3 status", {24'b0, s}, 32'h00);

    // 4: slow slave, second word overruns
    ack_delay = 40 * 16;
    base = n_log;
    do_write(32'h30000000, 32'hAAAA0001, 32'hAAAA0002);
    wait_idle("t4 idle");
    chk("t4 count", 32'(n_log - base), 32'd1);
    chk("t4 dat0", log_dat[base], 32'hAAAA0001);
    ack_delay = 2;
    do_status(s);
    chk("t4 status1", {24'b0, s}, 32'h01);
    do_status(s);
    chk("t4 status2", {24'b0, s}, 32'h00);

    // 5: truncated word, then a normal frame
    base = n_log;
    cs_on();
    spi_bits(32'h02, 8, r);
    spi_bits(32'h40000000, 32, r);
    spi_bits(32'h12345, 20, r);
    cs_off();
    repeat (50) @(negedge clk);
    chk("t5 no cycle", 32'(n_log - base), 32'd0);
    cs_on();
    spi_bits(32'h02, 8, r);
    spi_bits(32'h40000010, 32, r);
    spi_bits(32'h76543210, 32, r);
    cs_off();
    wait_idle("t5 idle");
    chk("t5 count", 32'(n_log - base), 32'd1);
    chk("t5 adr", log_adr[base], 32'h40000010);
    chk("t5 dat", log_dat[base], 32'h76543210);

    // unknown command keeps miso low
    cs_on();
    spi_bits(32'h9F, 8, r);
    spi_bits(32'hFFFF, 16, r);
    cs_off();
    chk("ign miso", r, 32'h0);
    do_status(s);
    chk("ign status", {24'b0, s}, 32'h00);

    // 6: slave never acks a read
    never_ack = 1'b1;
    cs_on();
    spi_bits(32'h03, 8, r);
    spi_bits(32'h50000000, 32, r);
    n = 0;
    while (!bus.wb_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6 cyc rise", {31'b0, bus.wb_cyc_o}, 32'h1);
    n = 0;
    while (bus.wb_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
`ifdef SPI_WB_TIMEOUT_EN
    chk("t6 cyc len", 32'(n), 32'd16);
    spi_bits(32'h00, 8, r);
    spi_bits(32'h0, 32, r1);
    cs_off();
    chk("t6 miso", r1, 32'hDEADBEEF);
    repeat (100) @(negedge clk);
    do_status(s);
    chk("t6 status", {24'b0, s}, 32'h02);
`else
    chk("t6 cyc held", 32'(n), 32'd200);
    chk("t6 cyc high", {31'b0, bus.wb_cyc_o}, 32'h1);
    cs_off();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
